// File: rtl/data_cache.sv
// Packet slot buffer ahead of the egress buffer manager: stores each packet in a
// fixed slot, publishes committed slot IDs, and streams a slot back out on request.
module data_cache #(
   parameter int NUM_SLOTS  = 16,
   parameter int SLOT_DEPTH = 128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [133:0] in_dc_data,
   input  logic         in_dc_data_wr,
   input  logic         in_dc_valid,
   input  logic         in_dc_valid_wr,
   output logic [7:0]   out_dc_md,
   output logic         out_dc_md_wr,
   input  logic [7:0]   in_dc_ID,
   input  logic         in_dc_ID_wr,
   output logic [133:0] out_dc_data,
   output logic         out_dc_data_wr,
   output logic [8:0]   out_dc_free_num,
   output logic [15:0]  out_dc_drop_cnt
);
   localparam int ID_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int OFF_W  = (SLOT_DEPTH > 1) ? $clog2(SLOT_DEPTH) : 1;
   localparam int ADDR_W = ID_W + OFF_W;
   localparam logic [1:0] TAG_HEAD = 2'b01;
   localparam logic [1:0] TAG_TAIL = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_READ, R_FREE} r_state_e;

   w_state_e               w_state_q, w_state_d;
   logic [ID_W-1:0]        w_id_q, w_id_d;
   logic [OFF_W-1:0]       w_off_q, w_off_d;
   logic                   w_ovf_q, w_ovf_d;
   logic [7:0]             md_q, md_d;
   logic                   md_wr_q, md_wr_d;
   logic [15:0]            drop_q, drop_d;
   logic [NUM_SLOTS-1:0]   free_map_q, free_map_d;
   logic [8:0]             free_num_q, free_num_d;
   r_state_e               r_state_q, r_state_d;
   logic [ID_W-1:0]        r_id_q, r_id_d;
   logic [OFF_W-1:0]       r_off_q, r_off_d;
   logic                   out_wr_q, out_wr_d;
   logic                   id_wr_prev_q, id_wr_prev_d;
   logic [133:0]           mem_rd_q;

   logic [133:0]           mem [NUM_SLOTS*SLOT_DEPTH];
   logic                   is_head, is_tail, start_pkt, free_any;
   logic                   alloc_en, w_rel_en, r_rel_en, wr_en, last_word;
   logic [ID_W-1:0]        alloc_id;
   logic [1:0]             drop_inc;
   logic [16:0]            drop_sum;
   logic [ADDR_W-1:0]      wr_addr, rd_addr;
   logic                   unused_id_bits;

   assign unused_id_bits = ^in_dc_ID;
   assign is_head = (in_dc_data[133:132] == TAG_HEAD);
   assign is_tail = (in_dc_data[133:132] == TAG_TAIL);

   // Lowest-index free slot, taken from the map as it stood at the start of the cycle.
   always_comb begin
      alloc_id = '0;
      free_any = |free_map_q;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (free_map_q[i]) alloc_id = ID_W'(i);
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_off_d   = w_off_q;
      w_ovf_d   = w_ovf_q;
      md_d      = md_q;
      md_wr_d   = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = {w_id_q, w_off_q};
      alloc_en  = 1'b0;
      w_rel_en  = 1'b0;
      drop_inc  = 2'd0;
      start_pkt = 1'b0;
      if (in_dc_data_wr) begin
         unique case (w_state_q)
            W_IDLE: start_pkt = is_head;
            W_STORE: begin
               if (is_head) begin
                  w_rel_en  = 1'b1;
                  drop_inc  = 2'd1;
                  start_pkt = 1'b1;
               end else begin
                  wr_en   = !w_ovf_q;
                  w_off_d = w_off_q + 1'b1;
                  if (is_tail) begin
                     w_state_d = W_IDLE;
                     if (in_dc_valid_wr && in_dc_valid && !w_ovf_q) begin
                        md_d    = 8'(w_id_q);
                        md_wr_d = 1'b1;
                     end else begin
                        w_rel_en = 1'b1;
                        drop_inc = 2'd1;
                     end
                  end else if (w_off_q == OFF_W'(SLOT_DEPTH - 1)) begin
                     w_ovf_d = 1'b1;
                  end
               end
            end
            W_DROP:  if (is_tail) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
         endcase
      end
      if (start_pkt) begin
         if (free_any) begin
            alloc_en  = 1'b1;
            w_id_d    = alloc_id;
            w_off_d   = OFF_W'(1);
            w_ovf_d   = 1'b0;
            wr_en     = 1'b1;
            wr_addr   = {alloc_id, {OFF_W{1'b0}}};
            w_state_d = W_STORE;
         end else begin
            drop_inc  = drop_inc + 2'd1;
            w_state_d = W_DROP;
         end
      end
   end

   // The current output word is the last one on a real tail or when the slot is exhausted.
   assign last_word = out_wr_q && ((mem_rd_q[133:132] == TAG_TAIL) || (r_off_q == '0));

   always_comb begin
      r_state_d    = r_state_q;
      r_id_d       = r_id_q;
      r_off_d      = r_off_q;
      out_wr_d     = 1'b0;
      r_rel_en     = 1'b0;
      id_wr_prev_d = in_dc_ID_wr;
      rd_addr      = {r_id_q, r_off_q};
      unique case (r_state_q)
         R_IDLE: begin
            if (in_dc_ID_wr && !id_wr_prev_q) begin
               r_id_d    = in_dc_ID[ID_W-1:0];
               r_off_d   = '0;
               r_state_d = R_READ;
            end
         end
         R_READ: begin
            if (last_word) begin
               r_state_d = R_FREE;
            end else begin
               out_wr_d = 1'b1;
               r_off_d  = r_off_q + 1'b1;
            end
         end
         R_FREE: begin
            r_rel_en  = 1'b1;
            r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      free_map_d = free_map_q;
      if (alloc_en) free_map_d[alloc_id] = 1'b0;
      if (w_rel_en) free_map_d[w_id_q] = 1'b1;
      if (r_rel_en) free_map_d[r_id_q] = 1'b1;
      free_num_d = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         free_num_d = free_num_d + 9'(free_map_d[i]);
      end
      drop_sum = {1'b0, drop_q} + 17'(drop_inc);
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_comb begin
      out_dc_data = '0;
      if (out_wr_q) begin
         out_dc_data = mem_rd_q;
         if (r_off_q == '0) out_dc_data[133:132] = TAG_TAIL;
      end
   end

   // NOTE: rst_n is active-high despite its name; all state uses non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         w_state_q    <= W_IDLE;
         w_id_q       <= '0;
         w_off_q      <= '0;
         w_ovf_q      <= 1'b0;
         md_q         <= '0;
         md_wr_q      <= 1'b0;
         drop_q       <= '0;
         free_map_q   <= '1;
         free_num_q   <= '0;
         r_state_q    <= R_IDLE;
         r_id_q       <= '0;
         r_off_q      <= '0;
         out_wr_q     <= 1'b0;
         id_wr_prev_q <= 1'b0;
      end else begin
         w_state_q    <= w_state_d;
         w_id_q       <= w_id_d;
         w_off_q      <= w_off_d;
         w_ovf_q      <= w_ovf_d;
         md_q         <= md_d;
         md_wr_q      <= md_wr_d;
         drop_q       <= drop_d;
         free_map_q   <= free_map_d;
         free_num_q   <= free_num_d;
         r_state_q    <= r_state_d;
         r_id_q       <= r_id_d;
         r_off_q      <= r_off_d;
         out_wr_q     <= out_wr_d;
         id_wr_prev_q <= id_wr_prev_d;
      end
   end

   // NOTE: the packet store is deliberately not reset; a slot is only read after it was written.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= in_dc_data;
      mem_rd_q <= mem[rd_addr];
   end

   assign out_dc_md       = md_q;
   assign out_dc_md_wr    = md_wr_q;
   assign out_dc_data_wr  = out_wr_q;
   assign out_dc_free_num = free_num_q;
   assign out_dc_drop_cnt = drop_q;
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: table-driven packet vectors, hand-written
// corner sequences and randomized traffic against a slot-level reference model.
module tb_data_cache;
   localparam int NUM_SLOTS  = 16;
   localparam int SLOT_DEPTH = 128;
   typedef logic [133:0] word_t;

   typedef struct {
      int len;
      bit vw;
      bit v;
      int exp_md;
      int exp_drop;
      int exp_free;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   word_t      in_dc_data;
   logic       in_dc_data_wr, in_dc_valid, in_dc_valid_wr;
   logic [7:0] out_dc_md;
   logic       out_dc_md_wr;
   logic [7:0] in_dc_ID;
   logic       in_dc_ID_wr;
   word_t      out_dc_data;
   logic       out_dc_data_wr;
   logic [8:0] out_dc_free_num;
   logic [15:0] out_dc_drop_cnt;

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;
   int unsigned tail_cyc, edge_cyc;
   word_t       rx_q[$];
   int unsigned rx_cyc_q[$];
   logic [7:0]  md_q[$];
   int unsigned md_cyc_q[$];

   bit          m_free[NUM_SLOTS];
   int          m_drop;
   int          m_len[NUM_SLOTS];
   int unsigned m_salt[NUM_SLOTS];
   vec_t        vecs[6];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   data_cache #(.NUM_SLOTS(NUM_SLOTS), .SLOT_DEPTH(SLOT_DEPTH)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_dc_data      (in_dc_data),
      .in_dc_data_wr   (in_dc_data_wr),
      .in_dc_valid     (in_dc_valid),
      .in_dc_valid_wr  (in_dc_valid_wr),
      .out_dc_md       (out_dc_md),
      .out_dc_md_wr    (out_dc_md_wr),
      .in_dc_ID        (in_dc_ID),
      .in_dc_ID_wr     (in_dc_ID_wr),
      .out_dc_data     (out_dc_data),
      .out_dc_data_wr  (out_dc_data_wr),
      .out_dc_free_num (out_dc_free_num),
      .out_dc_drop_cnt (out_dc_drop_cnt)
   );

   task automatic check(string name, word_t act, word_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Output monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (out_dc_data_wr) begin
         rx_q.push_back(out_dc_data);
         rx_cyc_q.push_back(cyc);
      end else if (out_dc_data != '0) begin
         check("data_zero_when_idle", out_dc_data, '0);
      end
      if (out_dc_md_wr) begin
         md_q.push_back(out_dc_md);
         md_cyc_q.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_dc_data     = '0;
      in_dc_data_wr  = 1'b0;
      in_dc_valid    = 1'b0;
      in_dc_valid_wr = 1'b0;
   endtask

   function automatic word_t mk_word(int idx, int len, int unsigned salt);
      logic [1:0] tag;
      if (idx == 0)            tag = 2'b01;
      else if (idx == len - 1) tag = 2'b10;
      else                     tag = 2'b11;
      return {tag, 4'h0, salt, 32'(idx), ~salt, 32'(len)};
   endfunction

   function automatic int model_free_num();
      int n = 0;
      for (int i = 0; i < NUM_SLOTS; i++) n += int'(m_free[i]);
      return n;
   endfunction

   // Slot-level model: lowest free slot, commit only well-formed kept packets that fit.
   function automatic int model_write(int len, bit vw, bit v, int unsigned salt);
      int id = -1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (m_free[i] && id < 0) id = i;
      end
      if (id < 0 || len > SLOT_DEPTH || !vw || !v) begin
         m_drop++;
         return -1;
      end
      m_free[id] = 1'b0;
      m_len[id]  = len;
      m_salt[id] = salt;
      return id;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_SLOTS; i++) m_free[i] = 1'b1;
      m_drop = 0;
   endtask

   task automatic send_packet(int len, int nsend, bit vw, bit v, int unsigned salt);
      for (int i = 0; i < nsend; i++) begin
         in_dc_data     = mk_word(i, len, salt);
         in_dc_data_wr  = 1'b1;
         in_dc_valid_wr = vw && (i == len - 1);
         in_dc_valid    = v && (i == len - 1);
         tail_cyc       = cyc;
         tick();
      end
      idle_inputs();
   endtask

   task automatic check_md(int exp);
      if (exp >= 0) begin
         check("md_count", md_q.size(), 1);
         if (md_q.size() > 0) begin
            check("md_id", md_q[0], exp);
            check("md_latency", md_cyc_q[0] - tail_cyc, 1);
         end
      end else begin
         check("md_none", md_q.size(), 0);
      end
      check("drop_cnt", out_dc_drop_cnt, m_drop);
      check("free_num", out_dc_free_num, model_free_num());
   endtask

   task automatic write_and_check(int len, bit vw, bit v, int unsigned salt);
      int exp;
      md_q.delete();
      md_cyc_q.delete();
      exp = model_write(len, vw, v, salt);
      send_packet(len, len, vw, v, salt);
      tick();
      tick();
      check_md(exp);
   endtask

   task automatic check_rx(int len, int unsigned salt);
      int gaps = 0;
      int bad = 0;
      check("rd_count", rx_q.size(), len);
      if (rx_q.size() > 0) check("rd_first_latency", rx_cyc_q[0] - edge_cyc, 2);
      for (int i = 0; i < rx_q.size(); i++) begin
         if (rx_cyc_q[i] != rx_cyc_q[0] + i) gaps++;
         if (i < len && rx_q[i] !== mk_word(i, len, salt)) bad++;
      end
      check("rd_back_to_back", gaps, 0);
      check("rd_word_mismatches", bad, 0);
   endtask

   task automatic start_read(int id, int hold);
      rx_q.delete();
      rx_cyc_q.delete();
      in_dc_ID    = 8'(id);
      in_dc_ID_wr = 1'b1;
      edge_cyc    = cyc;
      repeat (hold) tick();
      in_dc_ID_wr = 1'b0;
   endtask

   task automatic read_and_check(int id, int hold);
      start_read(id, hold);
      repeat (m_len[id] + 6) tick();
      m_free[id] = 1'b1;
      check_rx(m_len[id], m_salt[id]);
      check("free_num_after_read", out_dc_free_num, model_free_num());
   endtask

   task automatic do_reset();
      rst_n       = 1'b1;
      in_dc_ID    = '0;
      in_dc_ID_wr = 1'b0;
      idle_inputs();
      tick();
      tick();
      check("rst_md_wr", out_dc_md_wr, 0);
      check("rst_md", out_dc_md, 0);
      check("rst_data_wr", out_dc_data_wr, 0);
      check("rst_data", out_dc_data, 0);
      check("rst_free_num", out_dc_free_num, 0);
      check("rst_drop_cnt", out_dc_drop_cnt, 0);
      rst_n = 1'b0;
      tick();
      check("free_num_after_reset", out_dc_free_num, NUM_SLOTS);
      model_reset();
      md_q.delete();
      md_cyc_q.delete();
      rx_q.delete();
      rx_cyc_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int          ids[$];
      int          len, r, pick;
      word_t       w;

      // Basic commit, held-request read, discarded packet.
      do_reset();
      write_and_check(4, 1'b1, 1'b1, 32'h11);
      read_and_check(0, 10);
      write_and_check(4, 1'b1, 1'b0, 32'h12);

      // Table of packets from a clean reset, expectations derived by hand.
      vecs[0] = '{4,              1'b1, 1'b1,  0, 0, 15};
      vecs[1] = '{4,              1'b1, 1'b0, -1, 1, 15};
      vecs[2] = '{3,              1'b0, 1'b1, -1, 2, 15};
      vecs[3] = '{2,              1'b1, 1'b1,  1, 2, 14};
      vecs[4] = '{SLOT_DEPTH,     1'b1, 1'b1,  2, 2, 13};
      vecs[5] = '{SLOT_DEPTH + 1, 1'b1, 1'b1, -1, 3, 13};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         md_q.delete();
         md_cyc_q.delete();
         void'(model_write(vecs[i].len, vecs[i].vw, vecs[i].v, 32'h700 + i));
         send_packet(vecs[i].len, vecs[i].len, vecs[i].vw, vecs[i].v, 32'h700 + i);
         tick();
         tick();
         if (vecs[i].exp_md >= 0) begin
            check("vec_md_count", md_q.size(), 1);
            if (md_q.size() > 0) check("vec_md_id", md_q[0], vecs[i].exp_md);
         end else begin
            check("vec_md_none", md_q.size(), 0);
         end
         check("vec_drop_cnt", out_dc_drop_cnt, vecs[i].exp_drop);
         check("vec_free_num", out_dc_free_num, vecs[i].exp_free);
      end
      read_and_check(2, 3);

      // Lost tail: the new head allocates before the abandoned slot is released.
      do_reset();
      send_packet(6, 2, 1'b1, 1'b1, 32'h400);
      send_packet(3, 3, 1'b1, 1'b1, 32'h401);
      tick();
      tick();
      m_drop     = 1;
      m_free[1]  = 1'b0;
      m_len[1]   = 3;
      m_salt[1]  = 32'h401;
      check_md(1);
      read_and_check(1, 1);

      // All slots full, drop, then reuse of the freed slot.
      do_reset();
      for (int i = 0; i < NUM_SLOTS; i++) write_and_check(2 + i % 3, 1'b1, 1'b1, 32'h100 + i);
      check("free_all_used", out_dc_free_num, 0);
      write_and_check(5, 1'b1, 1'b1, 32'h200);
      check("full_drop_cnt", out_dc_drop_cnt, 1);
      read_and_check(5, 1);
      write_and_check(3, 1'b1, 1'b1, 32'h300);
      if (md_q.size() > 0) check("reuse_freed_id", md_q[0], 5);

      // Overflowing packet, then forced termination when reading the uncommitted slot.
      do_reset();
      write_and_check(SLOT_DEPTH + 2, 1'b1, 1'b1, 32'h500);
      start_read(0, 1);
      repeat (SLOT_DEPTH + 6) tick();
      check("forced_count", rx_q.size(), SLOT_DEPTH);
      if (rx_q.size() > 0) begin
         w = rx_q[rx_q.size() - 1];
         check("forced_last_tag", w[133:132], 2'b10);
         check("forced_first_latency", rx_cyc_q[0] - edge_cyc, 2);
      end
      check("free_after_forced", out_dc_free_num, NUM_SLOTS);

      // Reset in the middle of both a write and a read.
      do_reset();
      write_and_check(6, 1'b1, 1'b1, 32'h600);
      in_dc_ID    = 8'd0;
      in_dc_ID_wr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_dc_data    = mk_word(i, 10, 32'h601);
         in_dc_data_wr = 1'b1;
         tick();
      end
      check("read_active_before_reset", out_dc_data_wr, 1);
      rst_n       = 1'b1;
      in_dc_ID_wr = 1'b0;
      idle_inputs();
      tick();
      check("midrst_data_wr", out_dc_data_wr, 0);
      check("midrst_data", out_dc_data, 0);
      check("midrst_md_wr", out_dc_md_wr, 0);
      check("midrst_free_num", out_dc_free_num, 0);
      rst_n = 1'b0;
      tick();
      check("midrst_free_after", out_dc_free_num, NUM_SLOTS);
      rx_q.delete();
      md_q.delete();
      repeat (20) tick();
      check("midrst_no_data_wr", rx_q.size(), 0);
      check("midrst_no_md_wr", md_q.size(), 0);

      // Randomized traffic against the model.
      do_reset();
      for (int k = 0; k < 40; k++) begin
         ids.delete();
         for (int i = 0; i < NUM_SLOTS; i++) if (!m_free[i]) ids.push_back(i);
         if (ids.size() > 0 && $urandom_range(0, 2) == 0) begin
            pick = ids[$urandom_range(0, ids.size() - 1)];
            read_and_check(pick, $urandom_range(1, 4));
         end else begin
            len = $urandom_range(2, 12);
            r   = $urandom_range(0, 9);
            write_and_check(len, r != 0, r > 1, $urandom);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
